// File: rtl/reg_scoreboard_pkg.sv
// Shared parameters and helpers for the register scoreboard.
//   NUM_REGS : architectural registers tracked
//   REG_W    : register index width
//   CNT_W    : pending-write counter width (max in-flight writes per reg = 2**CNT_W-1)
//   STAT_W   : stall statistics counter width
package reg_scoreboard_pkg;

  localparam int NUM_REGS = 4;
  localparam int REG_W    = 2;
  localparam int CNT_W    = 2;
  localparam int STAT_W   = 16;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Number of decrements hitting one register this cycle (retire and cancel may coincide).
  function automatic logic [1:0] dec_count(input logic hit_a, input logic hit_b);
    return {1'b0, hit_a} + {1'b0, hit_b};
  endfunction

endpackage

// File: rtl/reg_scoreboard_counter.sv
// Pending-write counter for one architectural register.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   inc          : one write issued to this register this cycle
//   dec[1:0]     : writes leaving flight this cycle (retire + cancel, 0..2)
//   cnt          : current pending count (registered)
//   zero, max    : cnt == 0, cnt == CNT_MAX
//   uf_pulse     : this cycle's decrements exceed cnt+inc; counter clamps to 0
module sb_counter
  import reg_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             max,
  output logic             uf_pulse
);

  logic [CNT_W:0]   sum_ext;
  logic [CNT_W:0]   dec_ext;
  logic [CNT_W-1:0] cnt_next;

  assign sum_ext  = {1'b0, cnt} + {{CNT_W{1'b0}}, inc};
  assign dec_ext  = {{(CNT_W-1){1'b0}}, dec};
  assign uf_pulse = dec_ext > sum_ext;
  // Modulo arithmetic is exact whenever no underflow occurs; overflow is
  // prevented upstream by the capacity stall.
  assign cnt_next = cnt + {{(CNT_W-1){1'b0}}, inc} - CNT_W'(dec);

  assign zero = (cnt == '0);
  assign max  = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (uf_pulse)
      cnt <= '0;
    else
      cnt <= cnt_next;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes per architectural register and
// interlocks decode on RAW hazards and on pending-write capacity.
// Ports:
//   clk, reset_n               : clock, async active-low reset
//   issue_req                  : ID has an instruction wanting to issue
//   use_rs1/rs1, use_rs2/rs2   : source operands
//   issue_wr/issue_dest        : destination of the issuing instruction
//   retire_wr/retire_dest      : WB register-file write
//   cancel_wr/cancel_dest      : squashed in-flight write
//   stall, issue_ok            : combinational issue decision
//   busy_mask                  : per-register pending != 0 (registered)
//   underflow                  : sticky, a decrement hit an empty counter
//   stall_cnt                  : saturating count of stall cycles
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                issue_req,
  input  logic                use_rs1,
  input  logic [REG_W-1:0]    rs1,
  input  logic                use_rs2,
  input  logic [REG_W-1:0]    rs2,
  input  logic                issue_wr,
  input  logic [REG_W-1:0]    issue_dest,
  input  logic                retire_wr,
  input  logic [REG_W-1:0]    retire_dest,
  input  logic                cancel_wr,
  input  logic [REG_W-1:0]    cancel_dest,
  output logic                stall,
  output logic                issue_ok,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                underflow,
  output logic [STAT_W-1:0]   stall_cnt
);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [1:0]          dec [NUM_REGS];
  logic [NUM_REGS-1:0] inc_v;
  logic [NUM_REGS-1:0] zero_v;
  logic [NUM_REGS-1:0] max_v;
  logic [NUM_REGS-1:0] uf_v;
  logic [NUM_REGS-1:0] eff_nz;
  logic [NUM_REGS-1:0] dec_zero;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    assign dec[r] = dec_count(retire_wr && (retire_dest == REG_W'(r)),
                              cancel_wr && (cancel_dest == REG_W'(r)));
    // Effective count after this cycle's retire/cancel: a source being
    // written back now is bypassed through the register file, so not a hazard.
    assign eff_nz[r]   = {1'b0, cnt[r]} > {{(CNT_W-1){1'b0}}, dec[r]};
    assign dec_zero[r] = (dec[r] == 2'd0);
    assign inc_v[r]    = issue_ok && issue_wr && (issue_dest == REG_W'(r));

    sb_counter u_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .inc      (inc_v[r]),
      .dec      (dec[r]),
      .cnt      (cnt[r]),
      .zero     (zero_v[r]),
      .max      (max_v[r]),
      .uf_pulse (uf_v[r])
    );
  end

  // A full destination counter may still accept a new write if one of its
  // pending writes leaves this same cycle.
  assign stall = issue_req && ((use_rs1 && eff_nz[rs1]) ||
                               (use_rs2 && eff_nz[rs2]) ||
                               (issue_wr && max_v[issue_dest] && dec_zero[issue_dest]));
  assign issue_ok  = issue_req && !stall;
  assign busy_mask = ~zero_v;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (|uf_v)
        underflow <= 1'b1;
      if (stall && (stall_cnt != STAT_MAX))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
